// File: rtl/axi_lite_m.sv
// AXI4-Lite slave GPIO block: a read/write LED register and a read-only
// debounced switch register. Only one transaction is in flight at a time.
//
// Handshake rule: a transfer on any AXI channel happens on the rising edge
// where both valid and ready are high. This slave raises each ready for
// exactly one cycle in that channel's own state. It holds each response
// (bvalid/bresp or rvalid/rdata/rresp) stable until the matching ready has
// been sampled high.
module axi_lite_m #(
  parameter logic [31:0] ADDR_LED        = 32'h4,
  parameter logic [31:0] ADDR_SW         = 32'h8,
  parameter int          DEBOUNCE_CYCLES = 5
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,   // active-high asynchronous reset
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [1:0]  s_axi_bresp,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [31:0] led,
  input  logic [31:0] sw,
  output logic [3:0]  debug_state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [3:0] {
    IDLE, AW_ACK, W_WAIT, W_ACK, W_UPD, B_RESP, AR_ACK, R_FETCH, R_RESP
  } state_t;

  state_t         state, state_nxt;
  logic [31:0]    addr_q;
  logic [31:0]    wdata_q;
  logic [3:0]     wstrb_q;
  logic [31:0]    sw_sample;
  logic [31:0]    sw_reg;
  logic [CW-1:0]  deb_cnt;

  assign debug_state = state;

  // State register
  always_ff @(posedge s_axi_aclk or posedge s_axi_aresetn) begin
    if (s_axi_aresetn) state <= IDLE;
    else               state <= state_nxt;
  end

  // Next-state logic; each ready is a pure decode of its own state
  always_comb begin
    state_nxt     = state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_arready = 1'b0;
    case (state)
      IDLE: begin
        if (s_axi_awvalid)      state_nxt = AW_ACK;  // write has priority
        else if (s_axi_arvalid) state_nxt = AR_ACK;
      end
      AW_ACK: begin
        s_axi_awready = 1'b1;
        state_nxt     = W_WAIT;
      end
      W_WAIT:  if (s_axi_wvalid) state_nxt = W_ACK;
      W_ACK: begin
        s_axi_wready = 1'b1;
        state_nxt    = W_UPD;
      end
      W_UPD:   state_nxt = B_RESP;
      B_RESP:  if (s_axi_bready) state_nxt = IDLE;
      AR_ACK: begin
        s_axi_arready = 1'b1;
        state_nxt     = R_FETCH;
      end
      R_FETCH: state_nxt = R_RESP;
      R_RESP:  if (s_axi_rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address/data capture, register update and response generation
  always_ff @(posedge s_axi_aclk or posedge s_axi_aresetn) begin
    if (s_axi_aresetn) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      led          <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (s_axi_awvalid)      addr_q <= s_axi_awaddr;
          else if (s_axi_arvalid) addr_q <= s_axi_araddr;
        end
        W_WAIT: begin
          if (s_axi_wvalid) begin
            wdata_q <= s_axi_wdata;
            wstrb_q <= s_axi_wstrb;
          end
        end
        W_UPD: begin
          if (addr_q == ADDR_LED) begin
            for (int i = 0; i < 4; i++) begin
              if (wstrb_q[i]) led[8*i +: 8] <= wdata_q[8*i +: 8];
            end
            s_axi_bresp <= RESP_OKAY;
          end else begin
            s_axi_bresp <= RESP_SLVERR;  // includes the read-only switch register
          end
          s_axi_bvalid <= 1'b1;
        end
        B_RESP: begin
          if (s_axi_bready) s_axi_bvalid <= 1'b0;
        end
        R_FETCH: begin
          if (addr_q == ADDR_LED) begin
            s_axi_rdata <= led;
            s_axi_rresp <= RESP_OKAY;
          end else if (addr_q == ADDR_SW) begin
            s_axi_rdata <= sw_reg;
            s_axi_rresp <= RESP_OKAY;
          end else begin
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_SLVERR;
          end
          s_axi_rvalid <= 1'b1;
        end
        R_RESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Debounce: sample sw, wait DEBOUNCE_CYCLES, accept only if unchanged
  always_ff @(posedge s_axi_aclk or posedge s_axi_aresetn) begin
    if (s_axi_aresetn) begin
      deb_cnt   <= '0;
      sw_sample <= '0;
      sw_reg    <= '0;
    end else if (deb_cnt == '0) begin
      sw_sample <= sw;
      deb_cnt   <= CW'(1);
    end else if (deb_cnt == CW'(DEBOUNCE_CYCLES)) begin
      if (sw == sw_sample) sw_reg <= sw_sample;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_axi_lite_m.sv
// Self-checking bench for axi_lite_m: directed register-map cases followed by
// randomized transactions checked against a register-level model.
module tb_axi_lite_m;

  localparam int DEB = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata, led, sw;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [3:0]  debug_state;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: register contents as software would see them
  logic [31:0] led_m;
  logic [31:0] sw_m;

  axi_lite_m #(.ADDR_LED(32'h4), .ADDR_SW(32'h8), .DEBOUNCE_CYCLES(DEB)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata),
    .s_axi_wstrb(wstrb), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_bresp(bresp), .s_axi_araddr(araddr), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .led(led), .sw(sw),
    .debug_state(debug_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] strobe_mask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (s[i]) m = m | (32'hFF << (8 * i));
    return m;
  endfunction

  // Full write transaction; wdelay delays wvalid, bdelay delays bready
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int wdelay, input int bdelay);
    logic [31:0] exp_led;
    logic [1:0]  exp_resp;
    int          cyc, aw_cnt, w_cnt, ar_cnt, b_first, exp_lat;
    logic        aw_fire, w_fire, b_fire, w_done, done;
    if (a == 32'h4) begin
      exp_led  = (led_m & ~strobe_mask(s)) | (d & strobe_mask(s));
      exp_resp = 2'b00;
    end else begin
      exp_led  = led_m;
      exp_resp = 2'b10;
    end
    exp_lat = (wdelay + 3 > 5) ? wdelay + 3 : 5;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s;
    wvalid = (wdelay == 0); bready = 1'b0;
    cyc = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_first = -1;
    w_done = 1'b0; done = 1'b0;
    while (!done && cyc < 64) begin
      aw_fire = awvalid & awready;
      w_fire  = wvalid & wready;
      b_fire  = bvalid & bready;
      tick();
      cyc++;
      if (aw_fire) awvalid = 1'b0;
      if (w_fire) begin wvalid = 1'b0; w_done = 1'b1; end
      if (b_fire) begin
        bready = 1'b0;
        done   = 1'b1;
        check_eq("bvalid_drop", bvalid, 0);
      end else begin
        if (!w_done && !wvalid && cyc >= wdelay) wvalid = 1'b1;
        aw_cnt += int'(awready);
        w_cnt  += int'(wready);
        ar_cnt += int'(arready);
        if (bvalid) begin
          if (b_first < 0) begin
            b_first = cyc;
            check_eq("b_latency", cyc, exp_lat);
            check_eq("bresp", bresp, exp_resp);
          end else begin
            check_eq("bresp_hold", bresp, exp_resp);
          end
          if (cyc >= b_first + bdelay) bready = 1'b1;
        end
      end
    end
    check_eq("b_timeout", done, 1);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    check_eq("awready_pulses", aw_cnt, 1);
    check_eq("wready_pulses", w_cnt, 1);
    check_eq("arready_in_write", ar_cnt, 0);
    check_eq("led", led, exp_led);
    led_m = exp_led;
  endtask

  // Full read transaction; rdelay delays rready after rvalid appears
  task automatic axi_read(input logic [31:0] a, input int rdelay);
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    int          cyc, ar_cnt, wr_cnt, r_first;
    logic        ar_fire, r_fire, done;
    if (a == 32'h4) begin
      exp_data = led_m; exp_resp = 2'b00;
    end else if (a == 32'h8) begin
      exp_data = sw_m;  exp_resp = 2'b00;
    end else begin
      exp_data = '0;    exp_resp = 2'b10;
    end
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    cyc = 0; ar_cnt = 0; wr_cnt = 0; r_first = -1; done = 1'b0;
    while (!done && cyc < 64) begin
      ar_fire = arvalid & arready;
      r_fire  = rvalid & rready;
      tick();
      cyc++;
      if (ar_fire) arvalid = 1'b0;
      if (r_fire) begin
        rready = 1'b0;
        done   = 1'b1;
        check_eq("rvalid_drop", rvalid, 0);
        check_eq("rdata_clear", rdata, 0);
      end else begin
        ar_cnt += int'(arready);
        wr_cnt += int'(awready) + int'(wready);
        if (rvalid) begin
          if (r_first < 0) begin
            r_first = cyc;
            check_eq("r_latency", cyc, 3);
          end
          check_eq("rdata", rdata, exp_data);
          check_eq("rresp", rresp, exp_resp);
          if (cyc >= r_first + rdelay) rready = 1'b1;
        end
      end
    end
    check_eq("r_timeout", done, 1);
    arvalid = 1'b0; rready = 1'b0;
    check_eq("arready_pulses", ar_cnt, 1);
    check_eq("wr_ready_in_read", wr_cnt, 0);
  endtask

  // Hold sw long enough that the debouncer must have accepted it
  task automatic settle_sw(input logic [31:0] v);
    sw = v;
    repeat (2 * (DEB + 1)) tick();
    sw_m = v;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 4))
      0, 1:    return 32'h4;
      2:       return 32'h8;
      3:       return 32'h10;
      default: return $urandom();
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_awready"}, awready, 0);
    check_eq({tag, "_wready"}, wready, 0);
    check_eq({tag, "_arready"}, arready, 0);
    check_eq({tag, "_bvalid"}, bvalid, 0);
    check_eq({tag, "_rvalid"}, rvalid, 0);
    check_eq({tag, "_resps"}, {bresp, rresp}, 0);
    check_eq({tag, "_rdata"}, rdata, 0);
    check_eq({tag, "_led"}, led, 0);
  endtask

  // Watchdog in case a wait slips past its bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  // Main sequence
  initial begin
    rst = 1'b1;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0; sw = 0;
    led_m = 0; sw_m = 0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Basic LED write and delayed-ready read-back
    axi_write(32'h4, 32'h0000ABCD, 4'b1111, 0, 0);
    axi_read(32'h4, 3);

    // Debounced switch register
    sw = 32'hF;
    repeat (20) tick();
    sw_m = 32'hF;
    axi_read(32'h8, 0);
    for (int k = 0; k < 16; k++) begin
      sw = 32'h100 + k;
      repeat (2) tick();
    end
    axi_read(32'h8, 1);

    // Partial strobe and error responses
    axi_write(32'h4, 32'h12345678, 4'b0011, 1, 2);
    check_eq("led_partial", led, 32'h00005678);
    axi_write(32'h10, 32'hFFFFFFFF, 4'b1111, 3, 0);
    axi_write(32'h8, 32'hFFFFFFFF, 4'b1111, 0, 1);
    axi_read(32'h10, 2);

    // Write wins when both address channels are valid together
    araddr = 32'h4;
    arvalid = 1'b1;
    axi_write(32'h4, 32'hCAFE0000, 4'b1100, 0, 0);
    axi_read(32'h4, 0);

    // Reset while waiting for write data
    awaddr = 32'h4; awvalid = 1'b1; wvalid = 1'b0;
    tick();
    tick();
    awvalid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    tick();
    rst = 1'b0;
    led_m = 0;
    sw_m  = 0;
    tick();
    axi_read(32'h4, 0);

    // Randomized traffic
    settle_sw($urandom());
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) settle_sw($urandom());
      if ($urandom_range(0, 1) == 0)
        axi_write(pick_addr(), $urandom(), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 4), $urandom_range(0, 3));
      else
        axi_read(pick_addr(), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
